// File: rtl/be_response_model.sv
// Far-end Path ORAM backend responder: throttled command intake, a shadow position map
// with sticky violation reporting, and a backing store that replays stored chunks on reads.
module be_response_model #(
  parameter int ORAMU          = 32,
  parameter int ORAML          = 10,
  parameter int ORAMB          = 512,
  parameter int FEDWidth       = 32,
  parameter int NumBlocks      = 1024,
  parameter int CmdReadyPeriod = 100,
  parameter int LoadLatency    = 30
) (
  input  logic                Clock,
  input  logic                Reset,
  output logic                CmdReady,
  input  logic                CmdValid,
  input  logic [1:0]          Cmd,
  input  logic [ORAMU-1:0]    PAddr,
  input  logic [ORAML-1:0]    CurrentLeaf,
  input  logic [ORAML-1:0]    RemappedLeaf,
  output logic                StoreDataReady,
  input  logic                StoreDataValid,
  input  logic [FEDWidth-1:0] StoreData,
  output logic                LoadDataValid,
  input  logic                LoadDataReady,
  output logic [FEDWidth-1:0] LoadData,
  output logic                Error,
  output logic [2:0]          ErrorCode,
  output logic [31:0]         AccessCount
);
  localparam int Chunks = ORAMB / FEDWidth;
  localparam int CH_W   = (Chunks > 1) ? $clog2(Chunks) : 1;
  localparam int BLK_W  = (NumBlocks > 1) ? $clog2(NumBlocks) : 1;
  localparam int MEM_W  = (NumBlocks * Chunks > 1) ? $clog2(NumBlocks * Chunks) : 1;
  localparam int CNT_W  = (CmdReadyPeriod > 1) ? $clog2(CmdReadyPeriod) : 1;
  localparam int LAT_W  = $clog2(LoadLatency + 1) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CmdReadyPeriod - 1);
  localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(LoadLatency - 1);
  localparam logic [CH_W-1:0]  BEAT_LAST  = CH_W'(Chunks - 1);
  localparam logic [ORAMU-1:0] ADDR_LIMIT = ORAMU'(NumBlocks);

  localparam logic [1:0] CMD_APPEND  = 2'd1;
  localparam logic [1:0] CMD_READRMV = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_STORE, S_WAIT, S_LOAD} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [LAT_W-1:0]     lat_q;
  logic [CH_W-1:0]      beat_q;
  logic [1:0]           cmd_q;
  logic [ORAMU-1:0]     paddr_q;
  logic [ORAML-1:0]     cur_leaf_q, remap_q;
  logic [31:0]          access_q;
  logic                 error_q;
  logic [2:0]           code_q;
  logic [NumBlocks-1:0] exists_q, written_q;
  logic [FEDWidth-1:0]  load_data_q;

  logic [ORAML-1:0]     leaf_mem [NumBlocks];
  logic [FEDWidth-1:0]  data_mem [NumBlocks*Chunks];

  logic                 cmd_accept, store_fire, load_fire;
  logic                 in_range, is_load, last_beat, lat_done, load_start;
  logic [BLK_W-1:0]     blk_idx;
  logic [CH_W-1:0]      rd_beat;
  logic [MEM_W-1:0]     blk_base, wr_addr, rd_addr;
  logic [FEDWidth-1:0]  rd_word;
  logic [2:0]           chk_code;

  assign blk_idx   = paddr_q[BLK_W-1:0];
  assign in_range  = paddr_q < ADDR_LIMIT;
  assign is_load   = cmd_q[1];
  assign last_beat = beat_q == BEAT_LAST;
  assign lat_done  = lat_q >= LAT_LAST;

  // Prefetch: the word for the next beat is fetched the cycle before it is offered.
  assign rd_beat    = (state_q == S_LOAD) ? beat_q + 1'b1 : '0;
  assign blk_base   = MEM_W'(blk_idx) * MEM_W'(Chunks);
  assign wr_addr    = blk_base + MEM_W'(beat_q);
  assign rd_addr    = blk_base + MEM_W'(rd_beat);
  assign rd_word    = (in_range && written_q[blk_idx]) ? data_mem[rd_addr] : '0;
  assign load_start = (state_d == S_LOAD) && (state_q != S_LOAD);

  always_comb begin
    chk_code = 3'd0;
    if (!in_range)                              chk_code = 3'd4;
    else if (cmd_q == CMD_APPEND)               chk_code = exists_q[blk_idx] ? 3'd1 : 3'd0;
    else if (!exists_q[blk_idx])                chk_code = 3'd2;
    else if (leaf_mem[blk_idx] != cur_leaf_q)   chk_code = 3'd3;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal is given a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    cmd_accept     = 1'b0;
    store_fire     = 1'b0;
    load_fire      = 1'b0;
    CmdReady       = (state_q == S_IDLE) && (cnt_q == '0);
    StoreDataReady = (state_q == S_STORE);
    LoadDataValid  = (state_q == S_LOAD);
    unique case (state_q)
      S_IDLE:  if (CmdValid && CmdReady) begin
                 cmd_accept = 1'b1;
                 state_d    = S_CHECK;
               end
      S_CHECK: if (!is_load)     state_d = S_STORE;
               else if (lat_done) state_d = S_LOAD;
               else               state_d = S_WAIT;
      S_STORE: if (StoreDataValid) begin
                 store_fire = 1'b1;
                 if (last_beat) state_d = S_IDLE;
               end
      S_WAIT:  if (lat_done) state_d = S_LOAD;
      S_LOAD:  if (LoadDataReady) begin
                 load_fire = 1'b1;
                 if (last_beat) state_d = S_IDLE;
               end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q       <= '0;
      lat_q       <= '0;
      beat_q      <= '0;
      cmd_q       <= '0;
      paddr_q     <= '0;
      cur_leaf_q  <= '0;
      remap_q     <= '0;
      access_q    <= '0;
      error_q     <= 1'b0;
      code_q      <= '0;
      exists_q    <= '0;
      written_q   <= '0;
      load_data_q <= '0;
    end else begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      if (cmd_accept) begin
        cmd_q      <= Cmd;
        paddr_q    <= PAddr;
        cur_leaf_q <= CurrentLeaf;
        remap_q    <= RemappedLeaf;
        access_q   <= access_q + 32'd1;
        lat_q      <= LAT_W'(1);
        beat_q     <= '0;
      end
      // lat_q counts cycles since accept; CHECK occupies the first one.
      if (state_q == S_CHECK || state_q == S_WAIT) lat_q <= lat_q + 1'b1;
      if (state_q == S_CHECK) begin
        if (!error_q && chk_code != 3'd0) begin
          error_q <= 1'b1;
          code_q  <= chk_code;
        end
        if (in_range) exists_q[blk_idx] <= (cmd_q != CMD_READRMV);
      end
      if (store_fire && in_range) written_q[blk_idx] <= 1'b1;
      if (store_fire || load_fire) beat_q <= last_beat ? '0 : beat_q + 1'b1;
      if (load_start || (load_fire && !last_beat)) load_data_q <= rd_word;
      else if (load_fire)                          load_data_q <= '0;
    end
  end

  // NOTE: storage arrays are not reset; the written/exists bits mask stale contents instead.
  always_ff @(posedge Clock) begin
    if (state_q == S_CHECK && in_range) leaf_mem[blk_idx] <= remap_q;
    if (store_fire && in_range)         data_mem[wr_addr] <= StoreData;
  end

  assign LoadData    = load_data_q;
  assign Error       = error_q;
  assign ErrorCode   = code_q;
  assign AccessCount = access_q;
endmodule

// File: tb/tb_be_response_model.sv
// Self-checking bench for be_response_model: directed vector table, hand-written corner
// sequences, and randomized commands scored against a block-level reference model.
module tb_be_response_model;
  localparam int NB = 1024, CH = 16, PERIOD = 100, LAT = 30;
  localparam logic [1:0] UPD = 2'd0, APP = 2'd1, RD = 2'd2, RMV = 2'd3;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = '0;
  logic [31:0] paddr = '0;
  logic [9:0]  cur_leaf = '0, remap_leaf = '0;
  logic        st_valid = 1'b0, ld_ready = 1'b0;
  logic [31:0] st_data = '0;
  logic        cmd_ready, st_ready, ld_valid, error;
  logic [31:0] ld_data, acc_count;
  logic [2:0]  err_code;

  int n_cmp = 0, n_fail = 0;
  int cyc, last_acc;

  // Reference model: per-block map state and stored words, plus sticky error and count.
  bit          m_exists [NB];
  bit          m_written[NB];
  logic [9:0]  m_leaf   [NB];
  logic [31:0] m_mem    [NB*CH];
  bit          m_err;
  logic [2:0]  m_code;
  logic [31:0] m_count;

  be_response_model dut (
    .Clock(clk), .Reset(rst),
    .CmdReady(cmd_ready), .CmdValid(cmd_valid), .Cmd(cmd), .PAddr(paddr),
    .CurrentLeaf(cur_leaf), .RemappedLeaf(remap_leaf),
    .StoreDataReady(st_ready), .StoreDataValid(st_valid), .StoreData(st_data),
    .LoadDataValid(ld_valid), .LoadDataReady(ld_ready), .LoadData(ld_data),
    .Error(error), .ErrorCode(err_code), .AccessCount(acc_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && cmd_ready) check("ready_phase", 64'(cyc % PERIOD), 64'd0);
  end

  task automatic model_reset();
    for (int k = 0; k < NB; k++) begin
      m_exists[k]  = 1'b0;
      m_written[k] = 1'b0;
      m_leaf[k]    = '0;
    end
    m_err    = 1'b0;
    m_code   = '0;
    m_count  = '0;
    last_acc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0; st_valid = 1'b0; ld_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ld_valid", 64'(ld_valid), 64'd0);
    check("rst_st_ready", 64'(st_ready), 64'd0);
    check("rst_ld_data", 64'(ld_data), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_code", 64'(err_code), 64'd0);
    check("rst_count", 64'(acc_count), 64'd0);
    rst = 1'b0;
    model_reset();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  task automatic do_cmd(input logic [1:0] c, input int addr, input logic [9:0] cur,
                        input logic [9:0] rem, input logic [31:0] dbase, input int stall);
    logic [31:0] exp_beats[CH];
    logic [2:0]  code;
    bit          in_rng, first, rdy;
    int          n, i, ph, acc;
    in_rng = addr < NB;
    for (int k = 0; k < CH; k++) begin
      exp_beats[k] = '0;
      if (in_rng && m_written[addr]) exp_beats[k] = m_mem[addr*CH+k];
    end
    if (!in_rng)                   code = 3'd4;
    else if (c == APP)             code = m_exists[addr] ? 3'd1 : 3'd0;
    else if (!m_exists[addr])      code = 3'd2;
    else if (m_leaf[addr] != cur)  code = 3'd3;
    else                           code = 3'd0;
    if (!m_err && code != 3'd0) begin m_err = 1'b1; m_code = code; end
    if (in_rng) begin
      m_leaf[addr]   = rem;
      m_exists[addr] = (c != RMV);
      if (!c[1]) begin
        for (int k = 0; k < CH; k++) m_mem[addr*CH+k] = dbase + 32'(k);
        m_written[addr] = 1'b1;
      end
    end
    m_count++;

    cmd_valid = 1'b1; cmd = c; paddr = 32'(addr); cur_leaf = cur; remap_leaf = rem;
    n = 0;
    while (!cmd_ready && n < 3*PERIOD) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    acc = cyc;
    check("accept_phase", 64'(acc % PERIOD), 64'd0);
    if (last_acc >= 0) check("accept_spacing", 64'((acc - last_acc) >= PERIOD), 64'd1);
    last_acc = acc;
    @(negedge clk);
    cmd_valid = 1'b0;

    i = 0; n = 0;
    if (!c[1]) begin
      while (i < CH && n < 400) begin
        st_valid = (stall == 0) || ($urandom_range(0, 3) != 0);
        st_data  = dbase + 32'(i);
        if (st_valid && st_ready) i++;
        @(negedge clk); n++;
      end
      st_valid = 1'b0;
      if (i < CH) check("store_timeout", 64'(i), 64'(CH));
      check("store_ready_drop", 64'(st_ready), 64'd0);
    end else begin
      first = 1'b1; ph = 0;
      while (i < CH && n < 400) begin
        if (ld_valid) begin
          case (stall)
            0:       rdy = 1'b1;
            1:       rdy = (ph % 4 == 0) || (ph % 4 == 3);
            default: rdy = 1'($urandom_range(0, 1));
          endcase
          ph++;
          if (first) begin
            check("load_latency", 64'(cyc - acc), 64'(LAT));
            first = 1'b0;
          end
          check("load_beat", 64'(ld_data), 64'(exp_beats[i]));
          if (rdy) i++;
        end else begin
          rdy = 1'($urandom_range(0, 1));
        end
        ld_ready = rdy;
        @(negedge clk); n++;
      end
      ld_ready = 1'b0;
      if (i < CH) check("load_timeout", 64'(i), 64'(CH));
      check("load_valid_drop", 64'(ld_valid), 64'd0);
    end
    check("error", 64'(error), 64'(m_err));
    check("error_code", 64'(err_code), 64'(m_code));
    check("access_count", 64'(acc_count), 64'(m_count));
  endtask

  typedef struct {
    bit          rst;
    logic [1:0]  c;
    int          addr;
    logic [9:0]  cur;
    logic [9:0]  rem;
    logic [31:0] dbase;
    int          stall;
    bit          err;
    logic [2:0]  code;
  } vec_t;

  vec_t        vecs[21];
  int          n, a;
  logic [1:0]  rc;
  logic [9:0]  rcur;

  initial begin
    vecs[0]  = '{1'b1, APP, 5,    10'd0, 10'd7, 32'h100, 0, 1'b0, 3'd0};
    vecs[1]  = '{1'b0, RD,  5,    10'd7, 10'd7, 32'h0,   0, 1'b0, 3'd0};
    vecs[2]  = '{1'b1, RD,  9,    10'd0, 10'd1, 32'h0,   0, 1'b1, 3'd2};
    vecs[3]  = '{1'b0, APP, 5,    10'd0, 10'd2, 32'h200, 0, 1'b1, 3'd2};
    vecs[4]  = '{1'b0, APP, 5,    10'd0, 10'd2, 32'h300, 2, 1'b1, 3'd2};
    vecs[5]  = '{1'b1, APP, 3,    10'd0, 10'd4, 32'h500, 0, 1'b0, 3'd0};
    vecs[6]  = '{1'b0, UPD, 3,    10'd6, 10'd9, 32'h600, 2, 1'b1, 3'd3};
    vecs[7]  = '{1'b0, RD,  3,    10'd9, 10'd9, 32'h0,   1, 1'b1, 3'd3};
    vecs[8]  = '{1'b1, APP, 3,    10'd0, 10'd4, 32'h700, 0, 1'b0, 3'd0};
    vecs[9]  = '{1'b0, RMV, 3,    10'd4, 10'd5, 32'h0,   2, 1'b0, 3'd0};
    vecs[10] = '{1'b0, APP, 3,    10'd0, 10'd6, 32'h800, 0, 1'b0, 3'd0};
    vecs[11] = '{1'b0, RMV, 3,    10'd6, 10'd7, 32'h0,   1, 1'b0, 3'd0};
    vecs[12] = '{1'b0, RD,  3,    10'd7, 10'd7, 32'h0,   0, 1'b1, 3'd2};
    vecs[13] = '{1'b1, APP, 6,    10'd0, 10'd1, 32'h900, 0, 1'b0, 3'd0};
    vecs[14] = '{1'b0, APP, 6,    10'd0, 10'd1, 32'hA00, 0, 1'b1, 3'd1};
    vecs[15] = '{1'b0, RD,  6,    10'd1, 10'd1, 32'h0,   0, 1'b1, 3'd1};
    vecs[16] = '{1'b1, RD,  1024, 10'd0, 10'd3, 32'h0,   0, 1'b1, 3'd4};
    vecs[17] = '{1'b0, APP, 2000, 10'd0, 10'd3, 32'hC00, 0, 1'b1, 3'd4};
    vecs[18] = '{1'b0, APP, 1023, 10'd0, 10'd3, 32'hB00, 0, 1'b1, 3'd4};
    vecs[19] = '{1'b0, RD,  1023, 10'd3, 10'd3, 32'h0,   0, 1'b1, 3'd4};
    vecs[20] = '{1'b1, UPD, 0,    10'd0, 10'd0, 32'hD00, 0, 1'b1, 3'd2};

    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[v]) begin
      if (vecs[v].rst) do_reset();
      do_cmd(vecs[v].c, vecs[v].addr, vecs[v].cur, vecs[v].rem, vecs[v].dbase, vecs[v].stall);
      check("vec_error", 64'(error), 64'(vecs[v].err));
      check("vec_code", 64'(err_code), 64'(vecs[v].code));
    end

    // CmdValid held high across four ready windows: one accept per window.
    do_reset();
    cmd_valid = 1'b1; cmd = APP; paddr = 32'd8; remap_leaf = 10'd3;
    st_valid = 1'b1; st_data = 32'hABCD;
    while (cyc < 3*PERIOD + 50) @(negedge clk);
    cmd_valid = 1'b0; st_valid = 1'b0;
    check("held_accepts", 64'(acc_count), 64'd4);
    check("held_code", 64'(err_code), 64'd1);

    // Reset asserted in the middle of a stalled load.
    do_reset();
    do_cmd(APP, 4, 10'd0, 10'd11, 32'h4400, 0);
    cmd_valid = 1'b1; cmd = RD; paddr = 32'd4; cur_leaf = 10'd11; remap_leaf = 10'd12;
    n = 0;
    while (!cmd_ready && n < 3*PERIOD) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!ld_valid && n < 2*LAT) begin @(negedge clk); n++; end
    check("midload_valid", 64'(ld_valid), 64'd1);
    ld_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("midload_beat", 64'(ld_data), 64'(32'h4400 + k));
      @(negedge clk);
    end
    ld_ready = 1'b0;
    check("midload_held", 64'(ld_data), 64'h4403);
    @(negedge clk);
    check("midload_stall", 64'(ld_data), 64'h4403);
    #2 rst = 1'b1;
    #1;
    check("async_ld_valid", 64'(ld_valid), 64'd0);
    check("async_ld_data", 64'(ld_data), 64'd0);
    check("async_count", 64'(acc_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("resume_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    check("resume_ready_off", 64'(cmd_ready), 64'd0);
    do_cmd(RD, 4, 10'd0, 10'd1, 32'h0, 0);

    // Randomized episodes scored against the reference model.
    for (int e = 0; e < 4; e++) begin
      do_reset();
      for (int j = 0; j < 8; j++) begin
        a = ($urandom_range(0, 9) == 0) ? NB + $urandom_range(0, 40) : $urandom_range(0, 5);
        if (a < NB && !m_exists[a] && $urandom_range(0, 3) != 0) rc = APP;
        else rc = 2'($urandom_range(0, 3));
        rcur = 10'($urandom_range(0, 1023));
        if (a < NB && $urandom_range(0, 4) != 0) rcur = m_leaf[a];
        do_cmd(rc, a, rcur, 10'($urandom_range(0, 1023)), $urandom, $urandom_range(0, 2));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
